uart7n_tx_scheduler: RTL
========================

// Module: uart7n_tx_scheduler
// PURPOSE
//  Shares one uart7n_top transmitter between P_NUM_REQ requesters (e.g. echo path, status reporter, debug dump).
//  Round-robin arbitration; owns the TX handshake.
//  Per character: one enable_tx pulse, then wait for tx_data_sent before granting the next requester.
//  Sits between the requester logic and uart7n_top (.enable_tx_i, .data_tx_i, .tx_busy_o, .tx_data_sent_o).
// PARAMETERS
//  P_NUM_REQ        4      number of requesters, 2..8
//  P_DATA_W         7      character width (7N frame)
//  P_TIMEOUT_CYC    50000  watchdog limit in clk cycles; used only with UART7N_SCHED_TIMEOUT_EN
// PORTS
//  clk_i            in   1                    system clock
//  rst_n_i          in   1                    reset, asynchronous, active-low
//  req_i            in   P_NUM_REQ            level request; held until matching ack_o
//  data_i           in   P_NUM_REQ*P_DATA_W   requester k's char at [k*P_DATA_W +: P_DATA_W]
//  ack_o            out  P_NUM_REQ            1-cycle pulse: char of requester k latched
//  done_o           out  P_NUM_REQ            1-cycle pulse: requester k's char fully sent
//  tx_enable_o      out  1                    to uart enable_tx_i; 1-cycle pulse
//  tx_data_o        out  P_DATA_W             to uart TX data; stable from launch until done
//  tx_busy_i        in   1                    from uart tx_busy_o
//  tx_sent_i        in   1                    from uart tx_data_sent_o (level or pulse)
//  active_o         out  1                    high in any state except IDLE
//  timeout_o        out  1                    sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0; tx_data_o=0.
//  FSM states:
//   IDLE -> LAUNCH when any req_i is set.
//    - Winner = first set bit at or after the pointer, wrapping around.
//    - Same edge: latch winner's data into tx_data_o; pulse ack_o[k].
//    - Pointer := k+1 mod P_NUM_REQ.
//   LAUNCH (1 cycle): tx_enable_o=1 -> WAIT_SENT.
//   WAIT_SENT: on rising edge of tx_sent_i (registered edge detect):
//    - pulse done_o[k];
//    - -> GAP.
//   GAP: wait until tx_busy_i=0 and tx_sent_i=0 -> IDLE.
//  Latency: req_i high in IDLE -> ack_o next edge -> tx_enable_o one cycle later.
//  Min spacing between enable pulses: LAUNCH + WAIT_SENT + GAP + IDLE = 4 cycles plus UART frame time.
//  Simultaneous requests: pointer order only; no requester is starved. Max wait = P_NUM_REQ-1 chars.
//  A req_i that drops before ack_o is ignored (no ack, no send).
//  req_i still high after ack_o is a new request; it is arbitrated again next pass.
//  tx_sent_i already high on entering WAIT_SENT (stale level) is not a completion; only a 0->1 edge counts.
//  Async reset mid-frame: FSM to IDLE at once.
//   - In-flight char is abandoned with no done_o.
//   - Requester must re-request; the UART frame may finish on the line.
// CONFIGURATION
//  UART7N_SCHED_TIMEOUT_EN defined:
//   - Counter runs in WAIT_SENT and GAP.
//   - On reaching P_TIMEOUT_CYC: timeout_o := 1 (sticky until reset); pulse done_o[k]; -> IDLE.
//   - Counter clears on every state entry.
//  Undefined:
//   - No counter logic; timeout_o tied 0.
//   - A hung UART stalls the scheduler in WAIT_SENT forever.
// STRUCTURE
//  uart7n_pkg (shared):
//   - sched_state_t enum {IDLE, LAUNCH, WAIT_SENT, GAP};
//   - UART7N_DATA_W = 7;
//   - function clog2 for pointer and counter widths.
//  Sub-module uart7n_rr_arb: combinational round-robin pick.
//   - Inputs: req vector, pointer.
//   - Outputs: one-hot grant, index, any.
//   - Pointer register stays in the scheduler.
// TESTING
//  1 Single req_i=4'b0010, data 7'h41 -> ack_o[1] @+1, tx_enable_o @+2, tx_data_o=7'h41; tx_sent_i rise -> done_o[1].
//  2 req_i=4'b1111 held, distinct chars -> four sends, order 0,1,2,3.
//    Keep req_i[0] high -> order 0,1,2,3,0. Never two enables <4 cycles apart.
//  3 Pointer=3, req_i=4'b1001 -> grant 3 then 0 (wrap-around).
//  4 tx_sent_i held high from previous frame when entering WAIT_SENT -> no done_o until it falls and rises again.
//  5 Assert rst_n_i low during WAIT_SENT -> all outputs 0 asynchronously, no done_o.
//    After release, a pending req re-arbitrates from pointer 0.
//  6 (UART7N_SCHED_TIMEOUT_EN, P_TIMEOUT_CYC=16) tx_sent_i stuck 0 -> done_o + timeout_o=1 after 16 cycles.
//    Next request still served.

Source files
------------

// File: rtl/uart7n_pkg.sv
// Shared types and helpers for the uart7n TX scheduler slice.
package uart7n_pkg;

    localparam int unsigned UART7N_DATA_W = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_SENT = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    // Ceiling log2, usable in constant expressions for index and counter widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart7n_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module uart7n_rr_arb
    import uart7n_pkg::*;
#(
    parameter  int unsigned P_NUM_REQ = 4,
    localparam int unsigned IDX_W     = clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [P_NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            // one extra bit so ptr+i cannot overflow before the wrap subtract
            pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(P_NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(P_NUM_REQ);
            end
            cand = pos[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart7n_tx_scheduler.sv
// Round-robin sharing of one uart7n transmitter among P_NUM_REQ requesters.
// Optional watchdog on a hung UART: define UART7N_SCHED_TIMEOUT_EN.
module uart7n_tx_scheduler
    import uart7n_pkg::*;
#(
    parameter int unsigned P_NUM_REQ     = 4,
    parameter int unsigned P_DATA_W      = UART7N_DATA_W,
    parameter int unsigned P_TIMEOUT_CYC = 50000
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [P_NUM_REQ-1:0]            req_i,
    input  logic [P_NUM_REQ*P_DATA_W-1:0]   data_i,
    output logic [P_NUM_REQ-1:0]            ack_o,
    output logic [P_NUM_REQ-1:0]            done_o,
    output logic                            tx_enable_o,
    output logic [P_DATA_W-1:0]             tx_data_o,
    input  logic                            tx_busy_i,
    input  logic                            tx_sent_i,
    output logic                            active_o,
    output logic                            timeout_o
);

    localparam int unsigned IDX_W = clog2(P_NUM_REQ);
    localparam logic [P_NUM_REQ-1:0] REQ_LSB = {{(P_NUM_REQ - 1){1'b0}}, 1'b1};

    if ((P_NUM_REQ < 2) || (P_NUM_REQ > 8)) begin : g_bad_num_req
        $error("uart7n_tx_scheduler: P_NUM_REQ must be 2..8");
    end
    if (P_TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("uart7n_tx_scheduler: P_TIMEOUT_CYC must be at least 2");
    end

    sched_state_t            state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [P_DATA_W-1:0]     tx_data_q, tx_data_d;
    logic [P_NUM_REQ-1:0]    ack_q, ack_d;
    logic [P_NUM_REQ-1:0]    done_q, done_d;
    logic                    tx_en_q, tx_en_d;
    logic                    active_q, active_d;
    logic                    timeout_q, timeout_d;
    logic                    sent_prev_q;

    logic [P_NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic                    sent_rise_c;
    logic                    wd_hit_c;

    uart7n_rr_arb #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Only a 0->1 transition of tx_sent_i marks completion; a stale high level does not.
    assign sent_rise_c = tx_sent_i & ~sent_prev_q;

`ifdef UART7N_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = clog2(P_TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_run_c;

    assign wd_run_c = (state_q == WAIT_SENT) || (state_q == GAP);
    assign wd_hit_c = wd_run_c && (wd_cnt_q == WD_W'(P_TIMEOUT_CYC - 1));

    always_comb begin
        wd_cnt_d = '0;
        if (wd_run_c && (state_d == state_q)) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_hit_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (wd_hit_c) begin
                    state_d = IDLE;
                end else if (sent_rise_c) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (wd_hit_c || (!tx_busy_i && !tx_sent_i)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; everything lands in registers below.
    always_comb begin
        ack_d     = '0;
        done_d    = '0;
        tx_en_d   = 1'b0;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        active_d  = (state_d != IDLE);
        timeout_d = timeout_q | wd_hit_c;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ack_d     = arb_gnt;
                    idx_d     = arb_idx;
                    tx_data_d = data_i[int'(arb_idx) * P_DATA_W +: P_DATA_W];
                    ptr_d     = (arb_idx == IDX_W'(P_NUM_REQ - 1)) ? '0
                                                                   : arb_idx + IDX_W'(1);
                end
            end
            LAUNCH: begin
                tx_en_d = 1'b1;
            end
            WAIT_SENT: begin
                // a watchdog expiry in GAP reports nothing: done already went out on GAP entry
                if (wd_hit_c || sent_rise_c) begin
                    done_d = REQ_LSB << idx_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q       <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            tx_en_q     <= 1'b0;
            active_q    <= 1'b0;
            timeout_q   <= 1'b0;
            sent_prev_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            tx_en_q     <= tx_en_d;
            active_q    <= active_d;
            timeout_q   <= timeout_d;
            sent_prev_q <= tx_sent_i;
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign tx_enable_o = tx_en_q;
    assign tx_data_o   = tx_data_q;
    assign active_o    = active_q;
    assign timeout_o   = timeout_q;

endmodule
